// File: rtl/dlx_exec_if.sv
// dlx_exec_if: request/result bundle for the DLX execute stage (dlx_exec_pipe).
// The overflow signal exists only when DLX_EXEC_OVF_EN is defined.
interface dlx_exec_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  logic [IMM_WIDTH-1:0]  imm;
  logic [6:0]            control_in;
  logic [DATA_WIDTH-1:0] mem_data_read_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] aluout;
  logic                  carry;
  logic                  mem_data_wr_en;
  logic [DATA_WIDTH-1:0] mem_data_write_out;
`ifdef DLX_EXEC_OVF_EN
  logic                  overflow;

  modport master (
    output in_valid, src1, src2, imm, control_in, mem_data_read_in, out_ready,
    input  in_ready, out_valid, aluout, carry, mem_data_wr_en, mem_data_write_out, overflow
  );
  modport slave (
    input  in_valid, src1, src2, imm, control_in, mem_data_read_in, out_ready,
    output in_ready, out_valid, aluout, carry, mem_data_wr_en, mem_data_write_out, overflow
  );
`else
  modport master (
    output in_valid, src1, src2, imm, control_in, mem_data_read_in, out_ready,
    input  in_ready, out_valid, aluout, carry, mem_data_wr_en, mem_data_write_out
  );
  modport slave (
    input  in_valid, src1, src2, imm, control_in, mem_data_read_in, out_ready,
    output in_ready, out_valid, aluout, carry, mem_data_wr_en, mem_data_write_out
  );
`endif
endinterface

// File: rtl/dlx_exec_pipe.sv
// dlx_exec_pipe: two-stage DLX execute stage with merged ALU and valid/ready back-pressure.
// Define DLX_EXEC_OVF_EN to add the registered signed-overflow output.
module dlx_exec_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enable_ex,
  dlx_exec_if.slave bus
);
  localparam int unsigned SH_W = $clog2(DATA_WIDTH);
  localparam int unsigned HW   = DATA_WIDTH / 2;
  localparam int unsigned DW1  = DATA_WIDTH + 1;
  localparam int unsigned HW1  = HW + 1;
  localparam int unsigned MSB  = DATA_WIDTH - 1;

  localparam logic [2:0] OPS_SHIFT = 3'b000;
  localparam logic [2:0] OPS_ARITH = 3'b001;
  localparam logic [2:0] OPS_STORE = 3'b100;
  localparam logic [2:0] OPS_LOAD  = 3'b101;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_HADD = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  logic                  s1_adv, s2_adv;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic                  s1_valid_q, s1_valid_d;
  logic [2:0]            s1_opsel_q, s1_opsel_d, s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [DATA_WIDTH-1:0] s1_wdata_q, s1_wdata_d, s1_mdata_q, s1_mdata_d;
  logic                  out_valid_q, out_valid_d, carry_q, carry_d, wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] aluout_q, aluout_d, wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_carry;
  logic [DW1-1:0]        sum, diff;
  logic [HW1-1:0]        hsum;
  logic [SH_W-1:0]       amt;

  // ALU evaluated on the S1 operands; its result is captured by S2
  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    sum       = DW1'(s1_a_q) + DW1'(s1_b_q);
    diff      = DW1'(s1_a_q) - DW1'(s1_b_q);
    hsum      = HW1'(s1_a_q[HW-1:0]) + HW1'(s1_b_q[HW-1:0]);
    amt       = s1_b_q[SH_W-1:0];
    case (s1_opsel_q)
      OPS_ARITH: begin
        case (s1_op_q)
          OP_ADD:  begin res = sum[DATA_WIDTH-1:0];  res_carry = sum[DATA_WIDTH];  end
          OP_HADD: begin res = DATA_WIDTH'(hsum[HW-1:0]); res_carry = hsum[HW]; end
          OP_SUB:  begin res = diff[DATA_WIDTH-1:0]; res_carry = diff[DATA_WIDTH]; end
          OP_NOT:  res = ~s1_b_q;
          OP_AND:  res = s1_a_q & s1_b_q;
          OP_OR:   res = s1_a_q | s1_b_q;
          OP_XOR:  res = s1_a_q ^ s1_b_q;
          default: res = {s1_b_q[HW-1:0], HW'(0)};
        endcase
      end
      OPS_SHIFT: begin
        case (s1_op_q)
          3'b000, 3'b001: res = s1_a_q << amt;
          3'b010:         res = s1_a_q >> amt;
          3'b011:         res = DATA_WIDTH'($signed(s1_a_q) >>> amt);
          default:        res = '0;
        endcase
      end
      OPS_LOAD: begin
        case (s1_op_q)
          3'b000:  res = DATA_WIDTH'($signed(s1_mdata_q[7:0]));
          3'b100:  res = DATA_WIDTH'(s1_mdata_q[7:0]);
          3'b001:  res = DATA_WIDTH'($signed(s1_mdata_q[15:0]));
          3'b101:  res = DATA_WIDTH'(s1_mdata_q[15:0]);
          3'b011:  res = s1_mdata_q;
          default: res = '0;
        endcase
      end
      OPS_STORE: res = sum[DATA_WIDTH-1:0];
      default:   res = '0;
    endcase
  end

`ifdef DLX_EXEC_OVF_EN
  logic res_ovf, ovf_q, ovf_d;

  always_comb begin
    res_ovf = 1'b0;
    if (s1_opsel_q == OPS_ARITH && s1_op_q == OP_ADD)
      res_ovf = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
    else if (s1_opsel_q == OPS_ARITH && s1_op_q == OP_SUB)
      res_ovf = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
  end
`endif

  // Handshake and stage advance; a stalled stage keeps its contents
  always_comb begin
    s2_adv      = enable_ex && (!out_valid_q || bus.out_ready);
    s1_adv      = enable_ex && (!s1_valid_q || s2_adv);
    imm_ext     = DATA_WIDTH'($signed(bus.imm));
    s1_valid_d  = s1_valid_q;
    s1_opsel_d  = s1_opsel_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_wdata_d  = s1_wdata_q;
    s1_mdata_d  = s1_mdata_q;
    out_valid_d = out_valid_q;
    aluout_d    = aluout_q;
    carry_d     = carry_q;
    wr_en_d     = wr_en_q;
    wdata_d     = wdata_q;
`ifdef DLX_EXEC_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      s1_opsel_d = bus.control_in[6:4];
      s1_op_d    = bus.control_in[2:0];
      s1_a_d     = bus.src1;
      // loads and stores always take the immediate as address offset
      s1_b_d     = (bus.control_in[3] || bus.control_in[6:4] == OPS_LOAD ||
                    bus.control_in[6:4] == OPS_STORE) ? imm_ext : bus.src2;
      s1_wdata_d = bus.src2;
      s1_mdata_d = bus.mem_data_read_in;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      wr_en_d     = s1_valid_q && (s1_opsel_q == OPS_STORE);
      if (s1_valid_q) begin
        aluout_d = res;
        carry_d  = res_carry;
        wdata_d  = s1_wdata_q;
`ifdef DLX_EXEC_OVF_EN
        ovf_d    = res_ovf;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_opsel_q  <= '0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_wdata_q  <= '0;
      s1_mdata_q  <= '0;
      out_valid_q <= 1'b0;
      aluout_q    <= '0;
      carry_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wdata_q     <= '0;
`ifdef DLX_EXEC_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opsel_q  <= s1_opsel_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_wdata_q  <= s1_wdata_d;
      s1_mdata_q  <= s1_mdata_d;
      out_valid_q <= out_valid_d;
      aluout_q    <= aluout_d;
      carry_q     <= carry_d;
      wr_en_q     <= wr_en_d;
      wdata_q     <= wdata_d;
`ifdef DLX_EXEC_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready           = s1_adv && !rst;
  assign bus.out_valid          = out_valid_q;
  assign bus.aluout             = aluout_q;
  assign bus.carry              = carry_q;
  assign bus.mem_data_wr_en     = wr_en_q;
  assign bus.mem_data_write_out = wdata_q;
`ifdef DLX_EXEC_OVF_EN
  assign bus.overflow           = ovf_q;
`endif
endmodule

// File: tb/tb_dlx_exec_pipe.sv
// tb_dlx_exec_pipe: directed + random scoreboard bench for dlx_exec_pipe (DATA_WIDTH=32, IMM_WIDTH=16).
module tb_dlx_exec_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;

  typedef struct packed {
    logic [31:0] aluout;
    logic        carry;
    logic        wr_en;
    logic [31:0] wdata;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic enable_ex;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  dlx_exec_if #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) bus ();

  dlx_exec_pipe #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable_ex (enable_ex),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference result of one accepted request
  function automatic exp_t model(input logic [6:0] c, input logic [31:0] a, input logic [31:0] s2,
                                 input logic [15:0] i, input logic [31:0] m);
    exp_t        e;
    logic [31:0] b;
    logic [32:0] w;
    e = '0;
    b = (c[3] || c[6:5] == 2'b10) ? {{16{i[15]}}, i} : s2;
    case (c[6:4])
      3'b001: case (c[2:0])
        3'd0: begin
          w = {1'b0, a} + {1'b0, b};
          e.aluout = w[31:0]; e.carry = w[32];
          e.ovf = (a[31] == b[31]) && (w[31] != a[31]);
        end
        3'd1: begin
          w = 33'(a[15:0]) + 33'(b[15:0]);
          e.aluout = {16'h0, w[15:0]}; e.carry = w[16];
        end
        3'd2: begin
          e.aluout = a - b; e.carry = (a < b);
          e.ovf = (a[31] != b[31]) && (e.aluout[31] != a[31]);
        end
        3'd3: e.aluout = ~b;
        3'd4: e.aluout = a & b;
        3'd5: e.aluout = a | b;
        3'd6: e.aluout = a ^ b;
        default: e.aluout = {b[15:0], 16'h0};
      endcase
      3'b000: case (c[2:0])
        3'd0, 3'd1: e.aluout = a << b[4:0];
        3'd2:       e.aluout = a >> b[4:0];
        3'd3:       e.aluout = 32'($signed(a) >>> b[4:0]);
        default:    e.aluout = 32'h0;
      endcase
      3'b101: case (c[2:0])
        3'd0:    e.aluout = {{24{m[7]}}, m[7:0]};
        3'd4:    e.aluout = {24'h0, m[7:0]};
        3'd1:    e.aluout = {{16{m[15]}}, m[15:0]};
        3'd5:    e.aluout = {16'h0, m[15:0]};
        3'd3:    e.aluout = m;
        default: e.aluout = 32'h0;
      endcase
      3'b100: begin e.aluout = a + b; e.wr_en = 1'b1; e.wdata = s2; end
      default: ;
    endcase
    return e;
  endfunction

  // Called at the negedge: score drains and accepts, then advance past the next rising edge
  task automatic fin();
    exp_t e;
    if (bus.out_valid && bus.out_ready && enable_ex) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("aluout", 64'(bus.aluout), 64'(e.aluout));
        chk("carry", 64'(bus.carry), 64'(e.carry));
        chk("wr_en", 64'(bus.mem_data_wr_en), 64'(e.wr_en));
        if (e.wr_en) chk("wdata", 64'(bus.mem_data_write_out), 64'(e.wdata));
`ifdef DLX_EXEC_OVF_EN
        chk("overflow", 64'(bus.overflow), 64'(e.ovf));
`endif
      end
    end
    if (bus.in_valid && bus.in_ready)
      sb.push_back(model(bus.control_in, bus.src1, bus.src2, bus.imm, bus.mem_data_read_in));
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    fin();
  endtask

  task automatic drive(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] i, input logic [31:0] m);
    bus.control_in = c; bus.src1 = a; bus.src2 = b; bus.imm = i; bus.mem_data_read_in = m;
  endtask

  task automatic send(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [15:0] i, input logic [31:0] m);
    bit done;
    done = 1'b0;
    drive(c, a, b, i, m);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = bus.in_ready;
      fin();
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60 && sb.size() != 0; k++) cyc();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; enable_ex = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    drive(7'h0, 32'h0, 32'h0, 16'h0, 32'h0);
    cyc();
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_aluout", 64'(bus.aluout), 64'd0);
    chk("rst_carry", 64'(bus.carry), 64'd0);
    chk("rst_wr_en", 64'(bus.mem_data_wr_en), 64'd0);
    chk("rst_wdata", 64'(bus.mem_data_write_out), 64'd0);
`ifdef DLX_EXEC_OVF_EN
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
`endif
    fin();
    rst = 1'b0; bus.out_ready = 1'b1;

    // ADD wrap-around and two-cycle latency
    drive(7'b001_0_000, 32'hFFFF_FFFF, 32'h1, 16'h0, 32'h0);
    bus.in_valid = 1'b1;
    @(negedge clk); chk("add_in_ready", 64'(bus.in_ready), 64'd1); fin();
    bus.in_valid = 1'b0;
    @(negedge clk); chk("add_lat1", 64'(bus.out_valid), 64'd0); fin();
    @(negedge clk);
    chk("add_lat2", 64'(bus.out_valid), 64'd1);
    chk("add_sum", 64'(bus.aluout), 64'h0);
    chk("add_carry", 64'(bus.carry), 64'd1);
    fin();

    // Directed op coverage, back-to-back
    send(7'b001_0_010, 32'd5, 32'd7, 16'h0, 32'h0);
    send(7'b001_1_000, 32'h0, 32'h1234, 16'h8000, 32'h0);
    send(7'b000_0_011, 32'h8000_0000, 32'd4, 16'h0, 32'h0);
    send(7'b000_0_010, 32'h8000_0000, 32'd4, 16'h0, 32'h0);
    send(7'b000_0_000, 32'h0000_00F1, 32'd8, 16'h0, 32'h0);
    send(7'b000_0_100, 32'hFFFF_FFFF, 32'd1, 16'h0, 32'h0);
    send(7'b101_0_000, 32'h0, 32'h0, 16'h0, 32'h0000_00F0);
    send(7'b101_0_100, 32'h0, 32'h0, 16'h0, 32'h0000_00F0);
    send(7'b101_0_001, 32'h0, 32'h0, 16'h0, 32'h1234_8001);
    send(7'b101_0_011, 32'h0, 32'h0, 16'h0, 32'hA5A5_5A5A);
    send(7'b100_0_000, 32'h100, 32'hDEAD_BEEF, 16'hFFFC, 32'h0);
    send(7'b001_0_001, 32'h0001_FFFF, 32'h0002_0001, 16'h0, 32'h0);
    send(7'b001_0_111, 32'h0, 32'h0000_ABCD, 16'h0, 32'h0);
    send(7'b001_0_011, 32'h0, 32'h0F0F_0000, 16'h0, 32'h0);
    send(7'b001_0_110, 32'hFF00_FF00, 32'h0FF0_0FF0, 16'h0, 32'h0);
    send(7'b111_0_000, 32'h1, 32'h2, 16'h3, 32'h4);
`ifdef DLX_EXEC_OVF_EN
    send(7'b001_0_000, 32'h7FFF_FFFF, 32'h1, 16'h0, 32'h0);
    send(7'b001_0_010, 32'h8000_0000, 32'h1, 16'h0, 32'h0);
`endif
    drain();

    // Back-pressure: fill both stages, hold, freeze, then accept while draining
    bus.out_ready = 1'b0;
    drive(7'b001_0_000, 32'h10, 32'h20, 16'h0, 32'h0); bus.in_valid = 1'b1;
    @(negedge clk); chk("bp_rdy0", 64'(bus.in_ready), 64'd1); fin();
    drive(7'b001_0_010, 32'h3, 32'h9, 16'h0, 32'h0);
    @(negedge clk); chk("bp_rdy1", 64'(bus.in_ready), 64'd1); fin();
    drive(7'b001_0_110, 32'hAAAA_0000, 32'h00FF_00FF, 16'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_full_rdy", 64'(bus.in_ready), 64'd0);
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_data", 64'(bus.aluout), 64'(sb[0].aluout));
      fin();
    end
    enable_ex = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("frz_rdy", 64'(bus.in_ready), 64'd0);
      chk("frz_valid", 64'(bus.out_valid), 64'd1);
      chk("frz_data", 64'(bus.aluout), 64'(sb[0].aluout));
      fin();
    end
    enable_ex = 1'b1;
    @(negedge clk); chk("bp_accept_drain", 64'(bus.in_ready), 64'd1); fin();
    send(7'b000_0_001, 32'h1, 32'd31, 16'h0, 32'h0);
    drain();

    // Random traffic with random back-pressure and enable gaps
    for (int k = 0; k < 60; k++) begin
      logic [2:0] os;
      case ($urandom_range(0, 5))
        0:       os = 3'b000;
        1, 2:    os = 3'b001;
        3:       os = 3'b100;
        4:       os = 3'b101;
        default: os = 3'b111;
      endcase
      drive({os, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))},
            $urandom, $urandom, 16'($urandom), $urandom);
      bus.in_valid  = 1'($urandom_range(0, 3) != 0);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      enable_ex     = 1'($urandom_range(0, 7) != 0);
      cyc();
    end
    bus.in_valid = 1'b0; enable_ex = 1'b1;
    drain();

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(7'b100_0_000, 32'h200, 32'hCAFE_F00D, 16'h0004, 32'h0);
    send(7'b001_0_000, 32'h1, 32'h2, 16'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk); chk("rst2_in_ready", 64'(bus.in_ready), 64'd0); fin();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_aluout", 64'(bus.aluout), 64'd0);
    chk("rst2_carry", 64'(bus.carry), 64'd0);
    chk("rst2_wr_en", 64'(bus.mem_data_wr_en), 64'd0);
    chk("rst2_wdata", 64'(bus.mem_data_write_out), 64'd0);
    fin();
    bus.out_ready = 1'b1;
    drive(7'b001_0_010, 32'd5, 32'd7, 16'h0, 32'h0); bus.in_valid = 1'b1;
    @(negedge clk); chk("post_rst_rdy", 64'(bus.in_ready), 64'd1); fin();
    bus.in_valid = 1'b0;
    @(negedge clk); chk("post_rst_lat1", 64'(bus.out_valid), 64'd0); fin();
    @(negedge clk);
    chk("post_rst_lat2", 64'(bus.out_valid), 64'd1);
    chk("post_rst_sub", 64'(bus.aluout), 64'hFFFF_FFFE);
    fin();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
